tweakey_schedule: RTL

TWEAKEY_SCHEDULE -- requirements
Module: tweakey_schedule

---
 rtl/tweakey_schedule.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tweakey_schedule.sv
// -----------------------------------------------------------------------------
// tweakey_schedule
//
// Purpose:
//   Issues NUM_ROUNDS round tweakeys derived from a 128-bit master tweakey.
//   The first round tweakey is the master tweakey itself. Every accepted
//   transfer replaces the held tweakey by a fixed byte permutation of it,
//   with byte 0 additionally XORed by a 6-bit LFSR round constant.
//   Tweakeys are offered with a valid/ready handshake.
//
// Parameters:
//   NUM_ROUNDS  number of round tweakeys issued per key (1..31)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request to load key_in and begin a schedule (ignored when busy)
//   key_in     master tweakey, sampled only on an accepted start
//   tk         current round tweakey (held when not valid)
//   tk_valid   tk holds a valid round tweakey
//   tk_ready   consumer accepts tk this cycle
//   busy       high while a schedule is running or completing
//   done       one-cycle pulse after the last tweakey transfer
//   round_idx  index of the round tweakey on tk (only with the macro below)
//
// Configuration:
//   TWEAKEY_SCHEDULE_ROUND_IDX_EN  adds the round_idx[4:0] output
// -----------------------------------------------------------------------------
module tweakey_schedule #(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] tk,
  output logic         tk_valid,
  input  logic         tk_ready,
  output logic         busy,
  output logic         done
`ifdef TWEAKEY_SCHEDULE_ROUND_IDX_EN
  ,
  output logic [4:0]   round_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(NUM_ROUNDS - 1);
  localparam logic [5:0] RC_INIT  = 6'h01;

  state_t       state_r;
  state_t       state_s;
  logic [127:0] key_r;
  logic [5:0]   rc_r;
  logic [4:0]   cnt_r;
  logic         load_s;
  logic         xfer_s;
  logic         valid_r;
  logic         busy_r;
  logic         done_r;

  // Byte permutation: new byte i = old byte P[i],
  // P = {9,15,8,13,10,14,12,11,0,1,2,3,4,5,6,7}; byte 0 also takes the constant.
  function automatic logic [127:0] tk_next(input logic [127:0] key,
                                           input logic [5:0]   rc);
    logic [127:0] res;
    res[7:0]     = key[79:72] ^ {2'b00, rc};
    res[15:8]    = key[127:120];
    res[23:16]   = key[71:64];
    res[31:24]   = key[111:104];
    res[39:32]   = key[87:80];
    res[47:40]   = key[119:112];
    res[55:48]   = key[103:96];
    res[63:56]   = key[95:88];
    res[127:64]  = key[63:0];
    return res;
  endfunction

  // 6-bit round-constant LFSR step (XNOR feedback of the two top bits).
  function automatic logic [5:0] rc_next(input logic [5:0] rc);
    return {rc[4:0], ~(rc[5] ^ rc[4])};
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; start only matters in IDLE, transfers only in RUN.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    xfer_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (tk_ready) begin
          xfer_s = 1'b1;
          if (cnt_r == LAST_CNT) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Tweakey, round constant and round counter; all frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r <= 128'd0;
      rc_r  <= RC_INIT;
      cnt_r <= 5'd0;
    end else if (load_s) begin
      key_r <= key_in;
      rc_r  <= RC_INIT;
      cnt_r <= 5'd0;
    end else if (xfer_s) begin
      key_r <= tk_next(key_r, rc_r);
      rc_r  <= rc_next(rc_r);
      cnt_r <= cnt_r + 5'd1;
    end else begin
      key_r <= key_r;
      rc_r  <= rc_r;
      cnt_r <= cnt_r;
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      valid_r <= (state_s == RUN);
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  assign tk       = key_r;
  assign tk_valid = valid_r;
  assign busy     = busy_r;
  assign done     = done_r;

`ifdef TWEAKEY_SCHEDULE_ROUND_IDX_EN
  assign round_idx = cnt_r;
`endif

endmodule
